// File: rtl/fpnew_result_arbiter.sv
// Round-robin result arbiter for FPU operation-group result ports.
// Picks one requester per cycle with a wrap-around search that starts at a
// rotating pointer. Once a result has been presented but not yet accepted,
// the grant is held on that requester until the transfer happens.
//
// Handshake: a requester offers a result by raising req_i[i]. It must keep
// req_i[i] and its payload stable until the cycle where gnt_o[i] is high.
// Downstream sees req_o/data_o and accepts by raising gnt_i. A transfer
// happens on any cycle where req_o && gnt_i. req_o does not depend on gnt_i.
module fpnew_result_arbiter #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 38,
    parameter int IdxWidth  = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic [NumIn-1:0]           req_i,
    output logic [NumIn-1:0]           gnt_o,
    input  logic [NumIn*DataWidth-1:0] data_i,
    output logic                       req_o,
    input  logic                       gnt_i,
    output logic [DataWidth-1:0]       data_o,
    output logic [IdxWidth-1:0]        idx_o,
    output logic                       locked_o
);

    // Lock state: LOCKED means a presented result is waiting for gnt_i and
    // the selection must not move. It is visible on locked_o.
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e         lock_q, lock_d;
    logic [IdxWidth-1:0] rr_q, rr_d;
    logic [IdxWidth-1:0] locked_idx_q, locked_idx_d;
    logic [IdxWidth-1:0] rr_sel;
    logic                rr_found;
    logic                transfer;

    // Wrap-around search: first requester at or above rr_q, otherwise the
    // lowest requester. With no requester at all the pointer itself is shown.
    always_comb begin
        rr_sel   = rr_q;
        rr_found = 1'b0;
        for (int i = 0; i < NumIn; i++) begin
            if (!rr_found && req_i[i] && (IdxWidth'(i) >= rr_q)) begin
                rr_sel   = IdxWidth'(i);
                rr_found = 1'b1;
            end
        end
        for (int i = 0; i < NumIn; i++) begin
            if (!rr_found && req_i[i]) begin
                rr_sel   = IdxWidth'(i);
                rr_found = 1'b1;
            end
        end
    end

    // Selected index, downstream valid and the transfer condition.
    always_comb begin
        idx_o    = (lock_q == LOCKED) ? locked_idx_q : rr_sel;
        req_o    = (|req_i) && !flush_i;
        transfer = req_o && gnt_i;
        locked_o = (lock_q == LOCKED);
    end

    // Payload mux and one-hot grant back to the selected requester.
    always_comb begin
        data_o = '0;
        gnt_o  = '0;
        for (int i = 0; i < NumIn; i++) begin
            if (IdxWidth'(i) == idx_o) begin
                data_o   = data_i[i*DataWidth +: DataWidth];
                gnt_o[i] = transfer;
            end
        end
    end

    // Next-state: flush wins, then transfer advances the pointer past the
    // winner, then a stalled presentation locks onto the current index.
    always_comb begin
        lock_d       = lock_q;
        rr_d         = rr_q;
        locked_idx_d = locked_idx_q;
        if (flush_i) begin
            lock_d = UNLOCKED;
            rr_d   = '0;
        end else if (transfer) begin
            lock_d = UNLOCKED;
            rr_d   = (idx_o == IdxWidth'(NumIn - 1)) ? '0 : idx_o + IdxWidth'(1);
        end else if (req_o) begin
            lock_d       = LOCKED;
            locked_idx_d = idx_o;
        end
    end

    // State registers, cleared asynchronously so a reset drops any lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q       <= UNLOCKED;
            rr_q         <= '0;
            locked_idx_q <= '0;
        end else begin
            lock_q       <= lock_d;
            rr_q         <= rr_d;
            locked_idx_q <= locked_idx_d;
        end
    end

endmodule

// File: tb/tb_fpnew_result_arbiter.sv
// Directed bench for fpnew_result_arbiter: a 4-input instance for the main
// scenarios and a 3-input instance for the non-power-of-two wrap.
module tb_fpnew_result_arbiter;

    localparam int DW = 38;

    localparam logic [DW-1:0] D0 = 38'h00000000A0;
    localparam logic [DW-1:0] D1 = 38'h11111111B1;
    localparam logic [DW-1:0] D2 = 38'h22222222C2;
    localparam logic [DW-1:0] D3 = 38'h33333333D3;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [3:0]    req;
    logic [3:0]    gnt_out;
    logic [4*DW-1:0] data_in;
    logic          req_out;
    logic          gnt_in;
    logic [DW-1:0] data_out;
    logic [1:0]    idx;
    logic          locked;

    logic [2:0]    req3;
    logic [2:0]    gnt3_out;
    logic [3*DW-1:0] data3_in;
    logic          req3_out;
    logic          gnt3_in;
    logic [DW-1:0] data3_out;
    logic [1:0]    idx3;
    logic          locked3;

    logic [DW-1:0] exp_data [4];

    int n_vec;
    int n_err;

    fpnew_result_arbiter #(.NumIn(4), .DataWidth(DW)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .req_i   (req),
        .gnt_o   (gnt_out),
        .data_i  (data_in),
        .req_o   (req_out),
        .gnt_i   (gnt_in),
        .data_o  (data_out),
        .idx_o   (idx),
        .locked_o(locked)
    );

    fpnew_result_arbiter #(.NumIn(3), .DataWidth(DW)) dut3 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .req_i   (req3),
        .gnt_o   (gnt3_out),
        .data_i  (data3_in),
        .req_o   (req3_out),
        .gnt_i   (gnt3_in),
        .data_o  (data3_out),
        .idx_o   (idx3),
        .locked_o(locked3)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; req = 4'b0000; gnt_in = 1'b0;
        req3 = 3'b000; gnt3_in = 1'b0;
        #2;
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %b want 0", locked); end
        next_cycle();
        rst_n = 1'b1;
        #1;
        n_vec++; if (req_out !== 1'b0) begin n_err++; $display("FAIL reset_req_o got %b want 0", req_out); end
        n_vec++; if (gnt_out !== 4'b0000) begin n_err++; $display("FAIL reset_gnt_o got %b want 0000", gnt_out); end
        n_vec++; if (idx !== 2'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", idx); end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked_after got %b want 0", locked); end
        n_vec++; if (data_out !== D0) begin n_err++; $display("FAIL reset_data got %h want %h", data_out, D0); end
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            req = 4'b1111; gnt_in = 1'b1;
            #1;
            n_vec++; if (idx !== 2'(k % 4)) begin n_err++; $display("FAIL rr_idx[%0d] got %0d want %0d", k, idx, k % 4); end
            n_vec++; if (gnt_out !== (4'b0001 << (k % 4))) begin n_err++; $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt_out, 4'b0001 << (k % 4)); end
            n_vec++; if (data_out !== exp_data[k % 4]) begin n_err++; $display("FAIL rr_data[%0d] got %h want %h", k, data_out, exp_data[k % 4]); end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            req = 4'b0110; gnt_in = 1'b0;
            #1;
            n_vec++; if (idx !== 2'd1) begin n_err++; $display("FAIL stall_idx[%0d] got %0d want 1", k, idx); end
            n_vec++; if (locked !== (k > 0)) begin n_err++; $display("FAIL stall_locked[%0d] got %b want %b", k, locked, k > 0); end
            n_vec++; if (data_out !== D1) begin n_err++; $display("FAIL stall_data[%0d] got %h want %h", k, data_out, D1); end
            n_vec++; if (gnt_out !== 4'b0000) begin n_err++; $display("FAIL stall_gnt[%0d] got %b want 0000", k, gnt_out); end
            n_vec++; if (req_out !== 1'b1) begin n_err++; $display("FAIL stall_req_o[%0d] got %b want 1", k, req_out); end
        end
        next_cycle();
        gnt_in = 1'b1;
        #1;
        n_vec++; if (gnt_out !== 4'b0010) begin n_err++; $display("FAIL stall_release_gnt got %b want 0010", gnt_out); end
        next_cycle();
        #1;
        n_vec++; if (idx !== 2'd2) begin n_err++; $display("FAIL stall_next_idx got %0d want 2", idx); end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL stall_next_locked got %b want 0", locked); end
        n_vec++; if (gnt_out !== 4'b0100) begin n_err++; $display("FAIL stall_next_gnt got %b want 0100", gnt_out); end
    endtask

    // Pointer sits at 3 on entry.
    task automatic test_lock_hold();
        next_cycle();
        req = 4'b0000; gnt_in = 1'b1;
        #1;
        n_vec++; if (idx !== 2'd3) begin n_err++; $display("FAIL idle_idx got %0d want 3", idx); end
        n_vec++; if (req_out !== 1'b0) begin n_err++; $display("FAIL idle_req_o got %b want 0", req_out); end
        n_vec++; if (gnt_out !== 4'b0000) begin n_err++; $display("FAIL idle_gnt got %b want 0000", gnt_out); end
        next_cycle();
        req = 4'b0100; gnt_in = 1'b0;
        #1;
        n_vec++; if (idx !== 2'd2) begin n_err++; $display("FAIL hold_wrap_idx got %0d want 2", idx); end
        next_cycle();
        req = 4'b0101;
        #1;
        n_vec++; if (idx !== 2'd2) begin n_err++; $display("FAIL hold_idx got %0d want 2", idx); end
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL hold_locked got %b want 1", locked); end
        n_vec++; if (data_out !== D2) begin n_err++; $display("FAIL hold_data got %h want %h", data_out, D2); end
        next_cycle();
        gnt_in = 1'b1;
        #1;
        n_vec++; if (gnt_out !== 4'b0100) begin n_err++; $display("FAIL hold_release_gnt got %b want 0100", gnt_out); end
        next_cycle();
        #1;
        n_vec++; if (idx !== 2'd0) begin n_err++; $display("FAIL hold_after_idx got %0d want 0", idx); end
        n_vec++; if (gnt_out !== 4'b0001) begin n_err++; $display("FAIL hold_after_gnt got %b want 0001", gnt_out); end
    endtask

    // Pointer sits at 1 on entry.
    task automatic test_flush();
        next_cycle();
        req = 4'b1000; gnt_in = 1'b0;
        #1;
        n_vec++; if (idx !== 2'd3) begin n_err++; $display("FAIL flush_pre_idx got %0d want 3", idx); end
        next_cycle();
        #1;
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL flush_pre_locked got %b want 1", locked); end
        next_cycle();
        flush = 1'b1; gnt_in = 1'b1;
        #1;
        n_vec++; if (req_out !== 1'b0) begin n_err++; $display("FAIL flush_req_o got %b want 0", req_out); end
        n_vec++; if (gnt_out !== 4'b0000) begin n_err++; $display("FAIL flush_gnt got %b want 0000", gnt_out); end
        next_cycle();
        flush = 1'b0; req = 4'b1010; gnt_in = 1'b0;
        #1;
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL flush_after_locked got %b want 0", locked); end
        n_vec++; if (idx !== 2'd1) begin n_err++; $display("FAIL flush_after_idx got %0d want 1", idx); end
    endtask

    // Entry: locked on index 1 with req 1010 pending.
    task automatic test_reset_locked();
        next_cycle();
        gnt_in = 1'b1;
        #1;
        n_vec++; if (gnt_out !== 4'b0010) begin n_err++; $display("FAIL rl_pre_gnt got %b want 0010", gnt_out); end
        next_cycle();
        req = 4'b0100; gnt_in = 1'b0;
        #1;
        n_vec++; if (idx !== 2'd2) begin n_err++; $display("FAIL rl_pre_idx got %0d want 2", idx); end
        next_cycle();
        #1;
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL rl_locked got %b want 1", locked); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL rl_async_locked got %b want 0", locked); end
        req = 4'b1111;
        #1;
        n_vec++; if (idx !== 2'd0) begin n_err++; $display("FAIL rl_in_reset_idx got %0d want 0", idx); end
        next_cycle();
        rst_n = 1'b1; gnt_in = 1'b1;
        #1;
        n_vec++; if (idx !== 2'd0) begin n_err++; $display("FAIL rl_release_idx got %0d want 0", idx); end
        n_vec++; if (gnt_out !== 4'b0001) begin n_err++; $display("FAIL rl_release_gnt got %b want 0001", gnt_out); end
        next_cycle();
        req = 4'b0000; gnt_in = 1'b0;
    endtask

    task automatic test_wrap_three();
        logic [1:0] exp_idx [4];
        exp_idx[0] = 2'd0; exp_idx[1] = 2'd1; exp_idx[2] = 2'd2; exp_idx[3] = 2'd0;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            req3 = 3'b111; gnt3_in = 1'b1;
            #1;
            n_vec++; if (idx3 !== exp_idx[k]) begin n_err++; $display("FAIL wrap3_idx[%0d] got %0d want %0d", k, idx3, exp_idx[k]); end
            n_vec++; if (gnt3_out !== (3'b001 << exp_idx[k])) begin n_err++; $display("FAIL wrap3_gnt[%0d] got %b want %b", k, gnt3_out, 3'b001 << exp_idx[k]); end
            n_vec++; if (data3_out !== exp_data[exp_idx[k]]) begin n_err++; $display("FAIL wrap3_data[%0d] got %h want %h", k, data3_out, exp_data[exp_idx[k]]); end
        end
        next_cycle();
        req3 = 3'b000; gnt3_in = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_data[0] = D0; exp_data[1] = D1; exp_data[2] = D2; exp_data[3] = D3;
        data_in  = {D3, D2, D1, D0};
        data3_in = {D2, D1, D0};
        test_reset();
        test_round_robin();
        test_stall();
        test_lock_hold();
        test_flush();
        test_reset_locked();
        test_wrap_three();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
